// File: rtl/ppu_write_queue_pkg.sv
// Shared PPU write-path definitions: target indices, default entry layout, width helper.
package ppu_pkg;

  localparam int PPU_ADDR_W = 32'sd16;
  localparam int PPU_DATA_W = 32'sd16;
  localparam int PPU_TGT_W  = 32'sd1;

  localparam int TGT_OAM  = 32'sd0;
  localparam int TGT_MAIN = 32'sd1;

  typedef struct packed {
    logic [PPU_TGT_W-1:0]  tgt;
    logic [PPU_ADDR_W-1:0] addr;
    logic [PPU_DATA_W-1:0] data;
  } ppu_wr_entry_t;

  // A single target still needs a one-bit index field.
  function automatic int tgt_width(input int n);
    return (n > 32'sd1) ? $clog2(n) : 32'sd1;
  endfunction

endpackage

// File: rtl/ppu_write_queue_if.sv
// CPU-side write request bundle feeding the PPU write queue.
interface ppu_write_queue_if #(
  parameter int TGT_W  = 1,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic              wr_valid;
  logic              wr_ready;
  logic [TGT_W-1:0]  wr_tgt;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (output wr_valid, output wr_tgt, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_tgt, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/ppu_sync_fifo.sv
// Synchronous FIFO with show-ahead head and occupancy count; flush empties it in one cycle.
module ppu_sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (reset_n && !flush && push) mem_r[wr_ptr_r] <= din;
  end

  assign dout  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == CW'(0));

endmodule

// File: rtl/ppu_write_queue.sv
// CPU-to-PPU write queue: buffers CPU writes and drains them into the target memories
// only while the render-free window is open; otherwise the renderer owns every port.
module ppu_write_queue
  import ppu_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int DEPTH        = 16,
  parameter int NUM_TGT      = 2,
  parameter int HBLANK_DRAIN = 1,
  localparam int TGT_W       = tgt_width(NUM_TGT),
  localparam int CW          = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  ppu_write_queue_if.slave          wr_if,
  input  logic                      flush,
  input  logic                      clear_ovf,
  input  logic                      v_blank,
  input  logic                      h_blank,
  input  logic [NUM_TGT-1:0]        ren_en,
  input  logic [NUM_TGT-1:0]        ren_we,
  input  logic [NUM_TGT*ADDR_W-1:0] ren_addr,
  input  logic [NUM_TGT*DATA_W-1:0] ren_din,
  output logic [NUM_TGT-1:0]        mem_en,
  output logic [NUM_TGT-1:0]        mem_we,
  output logic [NUM_TGT*ADDR_W-1:0] mem_addr,
  output logic [NUM_TGT*DATA_W-1:0] mem_din,
  output logic [CW-1:0]             fill_level,
  output logic                      overflow,
  output logic                      drained
);

  typedef struct packed {
    logic [TGT_W-1:0]  tgt;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam logic HB_EN = (HBLANK_DRAIN != 0);

  entry_t        push_entry_s;
  entry_t        head_s;
  logic          window_s;
  logic          push_s;
  logic          pop_s;
  logic          full_s;
  logic          empty_s;
  logic          ovf_set_s;
  logic [CW-1:0] count_s;
  logic          overflow_r;

  assign window_s       = v_blank | (HB_EN & h_blank);
  assign wr_if.wr_ready = ~full_s;
  assign push_s         = wr_if.wr_valid & ~full_s & ~flush;
  // Reset and flush both suppress the drain strobe for their cycle.
  assign pop_s          = window_s & ~empty_s & ~flush & reset_n;
  assign ovf_set_s      = wr_if.wr_valid & full_s & ~flush;
  assign push_entry_s   = {wr_if.wr_tgt, wr_if.wr_addr, wr_if.wr_data};

  ppu_sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .push    (push_s),
    .pop     (pop_s),
    .din     (push_entry_s),
    .dout    (head_s),
    .count   (count_s),
    .full    (full_s),
    .empty   (empty_s)
  );

  // Sticky overflow; a new drop outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow_r <= 1'b0;
    end else if (ovf_set_s) begin
      overflow_r <= 1'b1;
    end else if (clear_ovf) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  // Memory port mux: queue head during the window, renderer passthrough otherwise.
  always_comb begin
    mem_en   = '0;
    mem_we   = '0;
    mem_addr = '0;
    mem_din  = '0;
    if (window_s) begin
      for (int t = 0; t < NUM_TGT; t++) begin
        mem_addr[t*ADDR_W +: ADDR_W] = head_s.addr;
        mem_din[t*DATA_W +: DATA_W]  = head_s.data;
        if (pop_s && (int'(head_s.tgt) == t)) begin
          mem_en[t] = 1'b1;
          mem_we[t] = 1'b1;
        end else begin
          mem_en[t] = 1'b0;
          mem_we[t] = 1'b0;
        end
      end
    end else begin
      mem_en   = ren_en;
      mem_we   = ren_we;
      mem_addr = ren_addr;
      mem_din  = ren_din;
    end
  end

  assign fill_level = count_s;
  assign overflow   = overflow_r;
  assign drained    = window_s & empty_s;

endmodule

// File: tb/tb_ppu_write_queue.sv
// Self-checking bench for ppu_write_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model (HBLANK_DRAIN=1 instance).
`timescale 1ns/1ps
module tb_ppu_write_queue;
  import ppu_pkg::*;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int NUM_TGT = 2;
  localparam int TGT_W  = 1;
  localparam int CW     = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, flush, clear_ovf, v_blank, h_blank;
  logic [NUM_TGT-1:0]        ren_en, ren_we;
  logic [NUM_TGT*ADDR_W-1:0] ren_addr;
  logic [NUM_TGT*DATA_W-1:0] ren_din;

  logic [NUM_TGT-1:0]        mem_en_a, mem_we_a, mem_en_b, mem_we_b;
  logic [NUM_TGT*ADDR_W-1:0] mem_addr_a, mem_addr_b;
  logic [NUM_TGT*DATA_W-1:0] mem_din_a, mem_din_b;
  logic [CW-1:0]             fill_a, fill_b;
  logic                      ovf_a, ovf_b, drained_a, drained_b;

  ppu_write_queue_if #(.TGT_W(TGT_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) wif_a ();
  ppu_write_queue_if #(.TGT_W(TGT_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) wif_b ();

  assign wif_b.wr_valid = wif_a.wr_valid;
  assign wif_b.wr_tgt   = wif_a.wr_tgt;
  assign wif_b.wr_addr  = wif_a.wr_addr;
  assign wif_b.wr_data  = wif_a.wr_data;

  ppu_write_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_TGT(NUM_TGT),
                    .HBLANK_DRAIN(1)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .wr_if(wif_a), .flush(flush), .clear_ovf(clear_ovf),
    .v_blank(v_blank), .h_blank(h_blank), .ren_en(ren_en), .ren_we(ren_we),
    .ren_addr(ren_addr), .ren_din(ren_din), .mem_en(mem_en_a), .mem_we(mem_we_a),
    .mem_addr(mem_addr_a), .mem_din(mem_din_a), .fill_level(fill_a), .overflow(ovf_a),
    .drained(drained_a));

  ppu_write_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_TGT(NUM_TGT),
                    .HBLANK_DRAIN(0)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .wr_if(wif_b), .flush(flush), .clear_ovf(clear_ovf),
    .v_blank(v_blank), .h_blank(h_blank), .ren_en(ren_en), .ren_we(ren_we),
    .ren_addr(ren_addr), .ren_din(ren_din), .mem_en(mem_en_b), .mem_we(mem_we_b),
    .mem_addr(mem_addr_b), .mem_din(mem_din_b), .fill_level(fill_b), .overflow(ovf_b),
    .drained(drained_b));

  int checks = 0;
  int failures = 0;

  // Reference model of instance A: an ordered list of pending writes and a sticky flag.
  ppu_wr_entry_t q[$];
  logic          m_ovf;

  function automatic logic m_window();
    return v_blank | h_blank;
  endfunction

  function automatic logic m_pop();
    return m_window() && (q.size() != 0) && !flush && reset_n;
  endfunction

  task automatic model_update();
    logic          full;
    logic          pop;
    ppu_wr_entry_t e;
    full = (q.size() == DEPTH);
    pop  = m_pop();
    if (!reset_n) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      if (wif_a.wr_valid && full && !flush) m_ovf = 1'b1;
      else if (clear_ovf) m_ovf = 1'b0;
      if (flush) begin
        q.delete();
      end else begin
        if (pop) void'(q.pop_front());
        if (wif_a.wr_valid && !full) begin
          e.tgt  = wif_a.wr_tgt;
          e.addr = wif_a.wr_addr;
          e.data = wif_a.wr_data;
          q.push_back(e);
        end
      end
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    wif_a.wr_valid = 1'b0;
    wif_a.wr_tgt   = 1'b0;
    wif_a.wr_addr  = 16'h0000;
    wif_a.wr_data  = 16'h0000;
    flush = 1'b0; clear_ovf = 1'b0; v_blank = 1'b0; h_blank = 1'b0;
    ren_en = 2'b00; ren_we = 2'b00; ren_addr = 32'h0; ren_din = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic push_n(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      wif_a.wr_valid = 1'b1;
      wif_a.wr_tgt   = 1'($urandom_range(0, 1));
      wif_a.wr_addr  = base + 16'(i);
      wif_a.wr_data  = 16'($urandom);
      tick();
    end
    wif_a.wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    ren_we = 2'b10; ren_en = 2'b11;
    settle();
    checks++; if (fill_a !== 5'd0) begin failures++; $display("FAIL reset_fill got=%0d exp=0", fill_a); end
    checks++; if (ovf_a !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b exp=0", ovf_a); end
    checks++; if (wif_a.wr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", wif_a.wr_ready); end
    checks++; if (mem_we_a !== 2'b10) begin failures++; $display("FAIL reset_passthru got=%b exp=10", mem_we_a); end
    idle_inputs();
  endtask

  task automatic test_window_closed();
    int n, first, last;
    logic addr_ok;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wif_a.wr_valid = 1'b1;
      wif_a.wr_tgt   = 1'(TGT_OAM);
      wif_a.wr_addr  = 16'h0010 + 16'(i);
      wif_a.wr_data  = 16'($urandom);
      settle();
      checks++; if (mem_we_a !== 2'b00) begin failures++; $display("FAIL closed_nostrobe got=%b exp=00", mem_we_a); end
      tick();
    end
    wif_a.wr_valid = 1'b0;
    settle();
    checks++; if (fill_a !== 5'd3) begin failures++; $display("FAIL closed_fill got=%0d exp=3", fill_a); end
    v_blank = 1'b1;
    n = 0; first = -1; last = -1; addr_ok = 1'b1;
    for (int c = 0; c < 6; c++) begin
      settle();
      if (mem_we_a[0]) begin
        if (mem_addr_a[15:0] !== 16'h0010 + 16'(n)) addr_ok = 1'b0;
        if (first < 0) first = c;
        last = c;
        n++;
      end
      tick();
    end
    v_blank = 1'b0;
    checks++; if (n !== 3) begin failures++; $display("FAIL drain_count got=%0d exp=3", n); end
    checks++; if (last - first !== 2) begin failures++; $display("FAIL drain_consecutive got=%0d exp=2", last - first); end
    checks++; if (addr_ok !== 1'b1) begin failures++; $display("FAIL drain_addr_order got=%0b exp=1", addr_ok); end
  endtask

  task automatic test_overflow();
    int n;
    do_reset();
    push_n(16, 16'h0200);
    wif_a.wr_valid = 1'b1;
    settle();
    checks++; if (wif_a.wr_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%0b exp=0", wif_a.wr_ready); end
    tick();
    wif_a.wr_valid = 1'b0;
    settle();
    checks++; if (ovf_a !== 1'b1) begin failures++; $display("FAIL ovf_set got=%0b exp=1", ovf_a); end
    checks++; if (fill_a !== 5'd16) begin failures++; $display("FAIL full_fill got=%0d exp=16", fill_a); end
    wif_a.wr_valid = 1'b1; clear_ovf = 1'b1;
    tick();
    wif_a.wr_valid = 1'b0; clear_ovf = 1'b0;
    settle();
    checks++; if (ovf_a !== 1'b1) begin failures++; $display("FAIL set_beats_clear got=%0b exp=1", ovf_a); end
    v_blank = 1'b1; n = 0;
    for (int c = 0; c < 20; c++) begin
      wif_a.wr_valid = (c == 0);
      settle();
      if (c == 0) begin
        checks++; if (wif_a.wr_ready !== 1'b0) begin failures++; $display("FAIL full_pop_ready got=%0b exp=0", wif_a.wr_ready); end
      end
      n += $countones(mem_we_a);
      tick();
    end
    wif_a.wr_valid = 1'b0; v_blank = 1'b0;
    settle();
    checks++; if (n !== 16) begin failures++; $display("FAIL full_drain_count got=%0d exp=16", n); end
    checks++; if (fill_a !== 5'd0) begin failures++; $display("FAIL full_drain_fill got=%0d exp=0", fill_a); end
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    settle();
    checks++; if (ovf_a !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%0b exp=0", ovf_a); end
  endtask

  task automatic test_hblank();
    int na, nb;
    do_reset();
    push_n(5, 16'h0300);
    h_blank = 1'b1; na = 0; nb = 0;
    for (int c = 0; c < 2; c++) begin
      settle();
      na += $countones(mem_we_a);
      nb += $countones(mem_we_b);
      tick();
    end
    h_blank = 1'b0;
    ren_en = 2'b11; ren_we = 2'b01; ren_addr = $urandom; ren_din = $urandom;
    settle();
    checks++; if (na !== 2) begin failures++; $display("FAIL hblank_writes got=%0d exp=2", na); end
    checks++; if (fill_a !== 5'd3) begin failures++; $display("FAIL hblank_fill got=%0d exp=3", fill_a); end
    checks++; if (mem_we_a !== ren_we || mem_addr_a !== ren_addr) begin failures++;
      $display("FAIL hblank_regain got=%b/%h exp=%b/%h", mem_we_a, mem_addr_a, ren_we, ren_addr); end
    checks++; if (nb !== 0) begin failures++; $display("FAIL vonly_writes got=%0d exp=0", nb); end
    checks++; if (fill_b !== 5'd5) begin failures++; $display("FAIL vonly_fill got=%0d exp=5", fill_b); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    int pt;
    do_reset();
    v_blank = 1'b1; pt = 0;
    for (int i = 0; i < 10; i++) begin
      wif_a.wr_valid = 1'b1;
      wif_a.wr_tgt   = 1'($urandom_range(0, 1));
      wif_a.wr_addr  = 16'h0100 + 16'(i);
      wif_a.wr_data  = 16'($urandom);
      settle();
      if (i == 0) begin
        checks++; if (mem_we_a !== 2'b00) begin failures++; $display("FAIL stream_nobypass got=%b exp=00", mem_we_a); end
      end else begin
        checks++; if (mem_we_a !== (2'b01 << pt) || mem_addr_a[pt*16 +: 16] !== 16'h0100 + 16'(i - 1)) begin
          failures++; $display("FAIL stream_commit got=%b/%h exp=%b/%h", mem_we_a, mem_addr_a[pt*16 +: 16],
                               2'b01 << pt, 16'h0100 + 16'(i - 1)); end
      end
      checks++; if (fill_a !== ((i == 0) ? 5'd0 : 5'd1)) begin failures++; $display("FAIL stream_fill got=%0d cycle=%0d", fill_a, i); end
      pt = int'(wif_a.wr_tgt);
      tick();
    end
    wif_a.wr_valid = 1'b0;
    settle();
    checks++; if (mem_we_a !== (2'b01 << pt)) begin failures++; $display("FAIL stream_last got=%b exp=%b", mem_we_a, 2'b01 << pt); end
    tick();
    settle();
    checks++; if (drained_a !== 1'b1 || fill_a !== 5'd0) begin failures++; $display("FAIL stream_drained got=%0b/%0d exp=1/0", drained_a, fill_a); end
    idle_inputs();
  endtask

  task automatic test_flush();
    do_reset();
    push_n(4, 16'h0400);
    v_blank = 1'b1; flush = 1'b1; wif_a.wr_valid = 1'b1;
    settle();
    checks++; if (mem_we_a !== 2'b00) begin failures++; $display("FAIL flush_nostrobe got=%b exp=00", mem_we_a); end
    tick();
    flush = 1'b0; wif_a.wr_valid = 1'b0;
    settle();
    checks++; if (fill_a !== 5'd0) begin failures++; $display("FAIL flush_fill got=%0d exp=0", fill_a); end
    checks++; if (ovf_a !== 1'b0 || mem_we_a !== 2'b00) begin failures++; $display("FAIL flush_after got=%0b/%b exp=0/00", ovf_a, mem_we_a); end
    idle_inputs();
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    push_n(6, 16'h0500);
    v_blank = 1'b1;
    tick();
    tick();
    reset_n = 1'b0;
    settle();
    checks++; if (mem_we_a !== 2'b00) begin failures++; $display("FAIL rst_nostrobe got=%b exp=00", mem_we_a); end
    tick();
    reset_n = 1'b1; v_blank = 1'b0;
    settle();
    checks++; if (fill_a !== 5'd0 || ovf_a !== 1'b0 || wif_a.wr_ready !== 1'b1) begin failures++;
      $display("FAIL rst_release got=%0d/%0b/%0b exp=0/0/1", fill_a, ovf_a, wif_a.wr_ready); end
  endtask

  task automatic test_random();
    logic                      win, pop;
    logic [NUM_TGT-1:0]        exp_we;
    int                        ht;
    do_reset();
    for (int k = 0; k < 800; k++) begin
      reset_n        = ($urandom_range(0, 99) >= 2);
      wif_a.wr_valid = ($urandom_range(0, 99) < 65);
      wif_a.wr_tgt   = 1'($urandom_range(0, 1));
      wif_a.wr_addr  = 16'($urandom);
      wif_a.wr_data  = 16'($urandom);
      flush          = ($urandom_range(0, 39) == 0);
      clear_ovf      = ($urandom_range(0, 15) == 0);
      v_blank        = ($urandom_range(0, 3) == 0);
      h_blank        = ($urandom_range(0, 4) == 0);
      ren_en = 2'($urandom); ren_we = 2'($urandom); ren_addr = $urandom; ren_din = $urandom;
      settle();
      win = m_window();
      pop = m_pop();
      checks++; if (wif_a.wr_ready !== (q.size() != DEPTH)) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%0b size=%0d", k, wif_a.wr_ready, q.size()); end
      checks++; if (fill_a !== CW'(q.size())) begin failures++; $display("FAIL rnd_fill cyc=%0d got=%0d exp=%0d", k, fill_a, q.size()); end
      checks++; if (ovf_a !== m_ovf) begin failures++; $display("FAIL rnd_ovf cyc=%0d got=%0b exp=%0b", k, ovf_a, m_ovf); end
      checks++; if (drained_a !== (win && q.size() == 0)) begin failures++; $display("FAIL rnd_drained cyc=%0d got=%0b", k, drained_a); end
      if (!win) begin
        checks++; if (mem_en_a !== ren_en || mem_we_a !== ren_we || mem_addr_a !== ren_addr || mem_din_a !== ren_din) begin
          failures++; $display("FAIL rnd_passthru cyc=%0d got=%b/%b/%h/%h exp=%b/%b/%h/%h", k, mem_en_a, mem_we_a,
                               mem_addr_a, mem_din_a, ren_en, ren_we, ren_addr, ren_din); end
      end else begin
        ht = pop ? int'(q[0].tgt) : 0;
        exp_we = pop ? (2'b01 << ht) : 2'b00;
        checks++; if (mem_we_a !== exp_we || mem_en_a !== exp_we) begin failures++;
          $display("FAIL rnd_strobe cyc=%0d got=%b/%b exp=%b", k, mem_en_a, mem_we_a, exp_we); end
        if (pop) begin
          checks++; if (mem_addr_a[ht*16 +: 16] !== q[0].addr || mem_din_a[ht*16 +: 16] !== q[0].data) begin failures++;
            $display("FAIL rnd_head cyc=%0d got=%h/%h exp=%h/%h", k, mem_addr_a[ht*16 +: 16], mem_din_a[ht*16 +: 16], q[0].addr, q[0].data); end
        end
      end
      tick();
    end
    reset_n = 1'b1;
    idle_inputs();
  endtask

  initial begin
    reset_n = 1'b0;
    m_ovf = 1'b0;
    idle_inputs();
    #2;
    test_reset();
    test_window_closed();
    test_overflow();
    test_hblank();
    test_back_to_back();
    test_flush();
    test_reset_mid_drain();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
